// File: rtl/prog_mem_loader.sv
// Unified 2**ADDR_SIZE x 32 CPU memory with a big-endian byte-stream boot loader that holds the CPU in reset.
// Define PROG_MEM_CHECKSUM_EN to require a trailing mod-256 checksum byte before the CPU is released.
module prog_mem_loader #(
   parameter int ADDR_SIZE  = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  start_load,
   input  logic [ADDR_SIZE-1:0]  mem_addr,
   input  logic                  mem_rw,
   input  logic [DATA_WIDTH-1:0] mem_datain,
   output logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  cpu_reset,
   output logic                  load_busy,
   output logic                  load_error,
   output logic [ADDR_SIZE:0]    words_loaded
);

   localparam int                 DEPTH     = 2**ADDR_SIZE;
   localparam logic [16:0]        MAX_WORDS = 17'(DEPTH);
   localparam logic [ADDR_SIZE:0] WL_ONE    = 1;

   typedef enum logic [2:0] {
      HDR_HI = 3'd0,
      HDR_LO = 3'd1,
      DATA   = 3'd2,
`ifdef PROG_MEM_CHECKSUM_EN
      CSUM   = 3'd3,
`endif
      RUN    = 3'd4,
      ERROR  = 3'd5
   } state_t;

`ifdef PROG_MEM_CHECKSUM_EN
   localparam state_t LOAD_DONE = CSUM;
`else
   localparam state_t LOAD_DONE = RUN;
`endif

   state_t                state_q, state_d;
   logic [7:0]            count_hi_q, count_hi_d;
   logic [15:0]           count_q, count_d;
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic [23:0]           word_buf_q, word_buf_d;
   logic [ADDR_SIZE:0]    words_loaded_q, words_loaded_d;
   logic                  cpu_reset_q, cpu_reset_d;
`ifdef PROG_MEM_CHECKSUM_EN
   logic [7:0]            sum_q, sum_d;
   logic [7:0]            sum_next;
`endif

   logic                  accept;
   logic [15:0]           n_hdr;
   logic                  mem_we;
   logic [ADDR_SIZE-1:0]  mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   assign in_ready     = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA)
`ifdef PROG_MEM_CHECKSUM_EN
                         || (state_q == CSUM)
`endif
                         ;
   assign load_busy    = in_ready;
   assign load_error   = (state_q == ERROR);
   assign cpu_reset    = cpu_reset_q;
   assign words_loaded = words_loaded_q;
   assign accept       = in_valid && in_ready;
   assign n_hdr        = {count_hi_q, in_data};
   assign mem_data_out = mem[mem_addr];

   always_comb begin
      state_d        = state_q;
      count_hi_d     = count_hi_q;
      count_d        = count_q;
      byte_idx_d     = byte_idx_q;
      word_buf_d     = word_buf_q;
      words_loaded_d = words_loaded_q;
      mem_we         = 1'b0;
      mem_waddr      = mem_addr;
      mem_wdata      = mem_datain;
`ifdef PROG_MEM_CHECKSUM_EN
      sum_next       = sum_q + in_data;
      sum_d          = sum_q;
      if (accept && state_q != CSUM) begin
         sum_d = sum_next;
      end
`endif
      case (state_q)
         HDR_HI: begin
            if (accept) begin
               count_hi_d = in_data;
               state_d    = HDR_LO;
            end
         end
         HDR_LO: begin
            if (accept) begin
               count_d        = n_hdr;
               byte_idx_d     = 2'd0;
               words_loaded_d = '0;
               if ({1'b0, n_hdr} > MAX_WORDS) begin
                  state_d = ERROR;
               end else if (n_hdr == 16'd0) begin
                  state_d = LOAD_DONE;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               byte_idx_d = byte_idx_q + 2'd1;
               word_buf_d = {word_buf_q[15:0], in_data};
               // Fourth byte completes the word; it is written on this same edge.
               if (byte_idx_q == 2'd3) begin
                  mem_we         = 1'b1;
                  mem_waddr      = words_loaded_q[ADDR_SIZE-1:0];
                  mem_wdata      = {word_buf_q, in_data};
                  words_loaded_d = words_loaded_q + WL_ONE;
                  if (17'(words_loaded_q) + 17'd1 == {1'b0, count_q}) begin
                     state_d = LOAD_DONE;
                  end
               end
            end
         end
`ifdef PROG_MEM_CHECKSUM_EN
         CSUM: begin
            if (accept) begin
               state_d = (sum_next == 8'd0) ? RUN : ERROR;
            end
         end
`endif
         RUN: begin
            if (start_load) begin
               state_d    = HDR_HI;
               byte_idx_d = 2'd0;
`ifdef PROG_MEM_CHECKSUM_EN
               sum_d      = 8'd0;
`endif
            end else if (mem_rw) begin
               mem_we = 1'b1;
            end
         end
         ERROR: begin
            if (start_load) begin
               state_d    = HDR_HI;
               byte_idx_d = 2'd0;
`ifdef PROG_MEM_CHECKSUM_EN
               sum_d      = 8'd0;
`endif
            end
         end
         default: begin
            state_d = HDR_HI;
         end
      endcase
      cpu_reset_d = (state_d != RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= HDR_HI;
         count_hi_q     <= 8'd0;
         count_q        <= 16'd0;
         byte_idx_q     <= 2'd0;
         word_buf_q     <= 24'd0;
         words_loaded_q <= '0;
         cpu_reset_q    <= 1'b1;
`ifdef PROG_MEM_CHECKSUM_EN
         sum_q          <= 8'd0;
`endif
      end else begin
         state_q        <= state_d;
         count_hi_q     <= count_hi_d;
         count_q        <= count_d;
         byte_idx_q     <= byte_idx_d;
         word_buf_q     <= word_buf_d;
         words_loaded_q <= words_loaded_d;
         cpu_reset_q    <= cpu_reset_d;
`ifdef PROG_MEM_CHECKSUM_EN
         sum_q          <= sum_d;
`endif
      end
   end

   // Memory array has no reset so a loaded program survives a reset pulse.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: streams boot images, scoreboards the expected memory words.
// Also exercises the PROG_MEM_CHECKSUM_EN build when that macro is defined.
module tb_prog_mem_loader;

   logic        clk;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        start_load;
   logic [11:0] mem_addr;
   logic        mem_rw;
   logic [31:0] mem_datain;
   logic [31:0] mem_data_out;
   logic        cpu_reset;
   logic        load_busy;
   logic        load_error;
   logic [12:0] words_loaded;

   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] prog_words[$];
   logic [31:0] model_mem [0:15];
   int          check_count;
   int          fail_count;

   prog_mem_loader dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .start_load   (start_load),
      .mem_addr     (mem_addr),
      .mem_rw       (mem_rw),
      .mem_datain   (mem_datain),
      .mem_data_out (mem_data_out),
      .cpu_reset    (cpu_reset),
      .load_busy    (load_busy),
      .load_error   (load_error),
      .words_loaded (words_loaded)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   task automatic sendByte(input logic [7:0] b, input int gap);
      int waited;
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_data  = b;
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready && waited < 20) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (!in_ready) begin
         checkOutput("acceptReady", 32'(in_ready), 32'd1);
      end else begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic pulseStart();
      start_load = 1'b1;
      @(posedge clk);
      #1;
      start_load = 1'b0;
   endtask

   // Streams prog_words as a boot image; each completed word is pushed to the scoreboard.
   task automatic applyStimulus(input int gap, input bit bad_csum, input int pulse_at);
      logic [7:0]  stream[$];
      logic [15:0] n;
      logic [31:0] w;
      logic [7:0]  sum;
      int          widx;
      n = 16'(prog_words.size());
      stream.push_back(n[15:8]);
      stream.push_back(n[7:0]);
      for (int i = 0; i < prog_words.size(); i++) begin
         w = prog_words[i];
         for (int j = 3; j >= 0; j--) begin
            stream.push_back(w[8*j +: 8]);
         end
      end
      sum = 8'd0;
      for (int k = 0; k < stream.size(); k++) begin
         sum = sum + stream[k];
      end
`ifdef PROG_MEM_CHECKSUM_EN
      stream.push_back((8'd0 - sum) + (bad_csum ? 8'd1 : 8'd0));
`else
      if (bad_csum) begin
         $display("[TB] checksum byte not used in this build (sum=%h)", sum);
      end
`endif
      for (int k = 0; k < stream.size(); k++) begin
         if (k == stream.size() - 1) begin
            checkOutput("cpuResetDuringLoad", 32'(cpu_reset), 32'd1);
         end
         if (k == pulse_at) begin
            start_load = 1'b1;
         end
         sendByte(stream[k], gap);
         start_load = 1'b0;
         widx = (k - 2) / 4;
         if (k >= 2 && ((k - 2) % 4) == 3 && widx < prog_words.size()) begin
            exp_q.push_back({12'(widx), prog_words[widx]});
            model_mem[widx] = prog_words[widx];
         end
      end
   endtask

   task automatic drainScoreboard();
      exp_t e;
      while (exp_q.size() > 0) begin
         e        = exp_q.pop_front();
         mem_addr = e.addr;
         #1;
         checkOutput("memWord", mem_data_out, e.data);
      end
   endtask

   task automatic checkMem(input logic [11:0] addr);
      mem_addr = addr;
      #1;
      checkOutput("memRetained", mem_data_out, model_mem[addr[3:0]]);
   endtask

   task automatic checkRunState(input int n_words);
      checkOutput("runCpuReset", 32'(cpu_reset), 32'd0);
      checkOutput("runInReady", 32'(in_ready), 32'd0);
      checkOutput("runBusy", 32'(load_busy), 32'd0);
      checkOutput("runWords", 32'(words_loaded), 32'(n_words));
   endtask

   initial begin
      check_count = 0;
      fail_count  = 0;
      reset       = 1'b1;
      in_data     = 8'd0;
      in_valid    = 1'b0;
      start_load  = 1'b0;
      mem_addr    = 12'd0;
      mem_rw      = 1'b0;
      mem_datain  = 32'd0;
      #12;
      checkOutput("rstCpuReset", 32'(cpu_reset), 32'd1);
      checkOutput("rstInReady", 32'(in_ready), 32'd1);
      checkOutput("rstBusy", 32'(load_busy), 32'd1);
      checkOutput("rstError", 32'(load_error), 32'd0);
      checkOutput("rstWords", 32'(words_loaded), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] basic two-word load");
      prog_words = '{32'h12345678, 32'h9ABCDEF0};
      applyStimulus(0, 1'b0, -1);
      checkRunState(2);
      drainScoreboard();

      $display("[TB] CPU write in RUN and while held in reset");
      mem_addr   = 12'h005;
      mem_datain = 32'hDEADBEEF;
      mem_rw     = 1'b1;
      @(posedge clk);
      #1;
      mem_rw = 1'b0;
      model_mem[5] = 32'hDEADBEEF;
      checkOutput("cpuWrite", mem_data_out, 32'hDEADBEEF);
      pulseStart();
      checkOutput("reloadCpuReset", 32'(cpu_reset), 32'd1);
      checkOutput("reloadInReady", 32'(in_ready), 32'd1);
      mem_addr   = 12'h005;
      mem_datain = 32'hCAFEF00D;
      mem_rw     = 1'b1;
      @(posedge clk);
      #1;
      mem_rw = 1'b0;
      checkMem(12'h005);

      $display("[TB] three-word load with ignored start_load mid-data");
      prog_words = '{32'h11111111, 32'h22222222, 32'h33333333};
      applyStimulus(0, 1'b0, 7);
      checkRunState(3);
      drainScoreboard();

      $display("[TB] gapped reload of the first image");
      pulseStart();
      prog_words = '{32'h12345678, 32'h9ABCDEF0};
      applyStimulus(3, 1'b0, -1);
      checkRunState(2);
      drainScoreboard();
      checkMem(12'h002);
      checkMem(12'h005);

      $display("[TB] start_load and in_valid together in RUN");
      in_data    = 8'h7F;
      in_valid   = 1'b1;
      start_load = 1'b1;
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      start_load = 1'b0;
      checkOutput("startWinsReady", 32'(in_ready), 32'd1);
      prog_words = '{32'h0BADF00D};
      applyStimulus(0, 1'b0, -1);
      checkRunState(1);
      drainScoreboard();
      checkMem(12'h001);

      $display("[TB] oversize header");
      pulseStart();
      sendByte(8'h10, 0);
      sendByte(8'h01, 0);
      checkOutput("errFlag", 32'(load_error), 32'd1);
      checkOutput("errCpuReset", 32'(cpu_reset), 32'd1);
      checkOutput("errInReady", 32'(in_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("errHeld", 32'(load_error), 32'd1);
      pulseStart();
      checkOutput("errClear", 32'(load_error), 32'd0);
      checkOutput("errReloadReady", 32'(in_ready), 32'd1);

      $display("[TB] full-depth header accepted");
      sendByte(8'h10, 0);
      sendByte(8'h00, 0);
      checkOutput("maxBusy", 32'(load_busy), 32'd1);
      checkOutput("maxNoError", 32'(load_error), 32'd0);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] async reset mid-load");
      sendByte(8'h00, 0);
      sendByte(8'h02, 0);
      sendByte(8'hA5, 0);
      sendByte(8'hA5, 0);
      sendByte(8'h5A, 0);
      sendByte(8'h5A, 0);
      exp_q.push_back({12'h000, 32'hA5A55A5A});
      model_mem[0] = 32'hA5A55A5A;
      sendByte(8'h11, 0);
      sendByte(8'h22, 0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("asyncCpuReset", 32'(cpu_reset), 32'd1);
      checkOutput("asyncInReady", 32'(in_ready), 32'd1);
      checkOutput("asyncBusy", 32'(load_busy), 32'd1);
      checkOutput("asyncWords", 32'(words_loaded), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drainScoreboard();
      checkMem(12'h001);

      $display("[TB] empty image");
      prog_words = '{};
      applyStimulus(0, 1'b0, -1);
      checkRunState(0);
      checkMem(12'h000);

`ifdef PROG_MEM_CHECKSUM_EN
      $display("[TB] checksum good and bad");
      pulseStart();
      prog_words = '{32'h01020304};
      applyStimulus(0, 1'b0, -1);
      checkRunState(1);
      drainScoreboard();
      pulseStart();
      model_mem[0] = 32'h0;
      applyStimulus(0, 1'b1, -1);
      checkOutput("csumErr", 32'(load_error), 32'd1);
      checkOutput("csumCpuReset", 32'(cpu_reset), 32'd1);
      drainScoreboard();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- Unified 4096x32 instruction/data memory for the CPU. Drives the CPU's mem_data_out and consumes its mem_addr, mem_rw and mem_datain.
- After reset, holds the CPU in reset while a byte-stream boot loader fills memory from address 0, then releases the CPU.
- Can be re-armed from RUN to reload a new program.

Parameters:
- ADDR_SIZE, 12, memory address width; depth = 2**ADDR_SIZE words.
- DATA_WIDTH, 32, word width; fixed at 32 (4 bytes per word), other values unsupported.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  boot stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte; byte transfers on posedge when in_valid && in_ready.
- start_load  input  1  single-cycle pulse; re-enters load from RUN or ERROR.
- mem_addr  input  ADDR_SIZE  CPU address.
- mem_rw  input  1  CPU write enable (1 = write).
- mem_datain  input  DATA_WIDTH  CPU write data.
- mem_data_out  output  DATA_WIDTH  read data to CPU.
- cpu_reset  output  1  reset to CPU, registered.
- load_busy  output  1  high in HDR_HI/HDR_LO/DATA/CSUM.
- load_error  output  1  high in ERROR.
- words_loaded  output  ADDR_SIZE+1  count of words written by the current or last load.

Behaviour:
- Reset values: state=HDR_HI, cpu_reset=1, in_ready=1, load_busy=1, load_error=0, words_loaded=0, byte index=0, word-count register=0. Memory contents are not cleared by reset.
- Read path: mem_data_out = mem[mem_addr], combinational (asynchronous read), valid in every state. The CPU relies on this in FETCH; there is no read latency.
- CPU write: in RUN only, when mem_rw=1, mem[mem_addr] <= mem_datain at posedge clk. mem_rw is ignored in all other states.
- Boot protocol (big-endian): count_hi, count_lo, then N*4 data bytes. N = {count_hi, count_lo} is 16-bit. Each word is {b0,b1,b2,b3}, written to addresses 0..N-1 in order. Memory beyond N-1 is unchanged.
- in_ready=1 in HDR_HI, HDR_LO, DATA and CSUM; 0 in RUN and ERROR. in_valid gaps stall the loader with no state change.
- HDR_HI: on accept, latch count_hi, go to HDR_LO.
- HDR_LO: on accept, form N.
  - N > 2**ADDR_SIZE: go to ERROR.
  - N == 0: go to RUN (or CSUM when enabled).
  - Otherwise: go to DATA, clear words_loaded.
- DATA: accept bytes, index 0..3. On the 4th byte, write the word at the posedge of acceptance to address words_loaded[ADDR_SIZE-1:0], then increment words_loaded. When words_loaded reaches N, go to RUN (or CSUM).
- RUN: cpu_reset=0. It falls on the posedge after the final accepted byte, so the first CPU clock sees program memory complete. start_load goes to HDR_HI and sets cpu_reset=1 on the same posedge.
- ERROR: cpu_reset stays 1, load_error=1. Leaves only on start_load (to HDR_HI) or reset.
- start_load is ignored in HDR_HI/HDR_LO/DATA/CSUM.
- Async reset mid-load: return to HDR_HI immediately and discard any partially assembled word. Words already written are retained.
- A simultaneous in_valid and start_load in RUN: start_load wins, and the byte is not accepted (in_ready=0 in RUN).

Optional Feature:
- Macro: PROG_MEM_CHECKSUM_EN.
- Defined: a running 8-bit sum (mod 256) covers both header bytes and all data bytes, cleared on entry to HDR_HI. After the last data byte (or after HDR_LO when N==0), the state goes to CSUM, which accepts one byte S.
  - (sum + S) mod 256 == 0: go to RUN.
  - Otherwise: go to ERROR. Words already written remain in memory.
- Not defined: no CSUM state and no sum register; the loader goes straight to RUN.

Test Plan:
- Stream 00 02 12 34 56 78 9A BC DE F0 -> mem[0]=0x12345678, mem[1]=0x9ABCDEF0, words_loaded=2, cpu_reset falls 1 cycle after the F0 acceptance, in_ready=0 afterwards.
- Same stream with in_valid low for 3 cycles between each byte -> identical memory and outputs; no extra writes.
- Header 10 01 (N=4097) -> ERROR, load_error=1, cpu_reset=1, in_ready=0; start_load pulse -> HDR_HI, load_error=0.
- In RUN, mem_rw=1, mem_addr=0x005, mem_datain=0xDEADBEEF for one cycle -> next cycle mem_data_out=0xDEADBEEF at addr 0x005. The same write attempted while cpu_reset=1 -> mem[5] unchanged.
- Async reset asserted after 2 data bytes of word 1 of a 2-word load -> state HDR_HI, cpu_reset=1, mem[0] retained, mem[1] unchanged.
- With PROG_MEM_CHECKSUM_EN: stream 00 01 01 02 03 04 F5 -> RUN. Same stream with F6 as the last byte -> ERROR, mem[0]=0x01020304.
